// File: rtl/kanagawa_loop_pkg.sv
// Shared helpers for the kanagawa loop generator/collector pair: record field
// access and the is-last-thread flag convention.
package kanagawa_loop_pkg;

    // Widest record the helpers can handle; records are zero-extended to this.
    localparam int unsigned FIELD_MAX_W = 512;

    typedef logic [FIELD_MAX_W-1:0] field_vec_t;

    typedef enum logic [1:0] {
        OUT_HOLD = 2'd0,
        OUT_LOAD = 2'd1,
        OUT_POP  = 2'd2
    } out_action_e;

    function automatic field_vec_t field_mask(input int unsigned width);
        field_vec_t one_v;
        one_v = field_vec_t'(1'b1);
        if (width >= FIELD_MAX_W) begin
            return ~field_vec_t'(1'b0);
        end else begin
            return (one_v << width) - one_v;
        end
    endfunction

    function automatic field_vec_t field_extract(input field_vec_t rec,
                                                 input int unsigned offset,
                                                 input int unsigned width);
        return (rec >> offset) & field_mask(width);
    endfunction

    function automatic field_vec_t field_insert(input field_vec_t rec,
                                                input field_vec_t val,
                                                input int unsigned offset,
                                                input int unsigned width);
        field_vec_t m;
        m = field_mask(width) << offset;
        return (rec & ~m) | ((val << offset) & m);
    endfunction

    // The generator marks a loop's final thread with a single set flag bit.
    function automatic logic is_last(input field_vec_t rec,
                                     input int unsigned last_offset);
        field_vec_t t;
        t = rec >> last_offset;
        return t[0];
    endfunction

endpackage

// File: rtl/kanagawa_loop_collector_out_reg.sv
// One-entry show-ahead holding register for loop summaries, with an underflow
// flag for reads that arrive while nothing is held.
module kanagawa_loop_collector_out_reg
    import kanagawa_loop_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rden,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             underflow
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             underflow_r;
    out_action_e      action_s;

    // Select the register action; a load in the same cycle as a pop wins.
    always_comb begin
        action_s = OUT_HOLD;
        if (load) begin
            action_s = OUT_LOAD;
        end else if (rden && valid_r) begin
            action_s = OUT_POP;
        end else begin
            action_s = OUT_HOLD;
        end
    end

    // Holding register, valid bit and registered underflow pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_r      <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= rden & ~valid_r;
            case (action_s)
                OUT_LOAD: begin
                    data_r  <= load_data;
                    valid_r <= 1'b1;
                end
                OUT_POP: begin
                    valid_r <= 1'b0;
                end
                OUT_HOLD: begin
                    valid_r <= valid_r;
                end
                default: begin
                    valid_r <= valid_r;
                end
            endcase
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign underflow = underflow_r;

endmodule

// File: rtl/kanagawa_loop_collector.sv
// Collapses each loop's per-thread record stream into one summary record whose
// counter field carries the loop's max thread ID; checks thread-ID continuity.
module kanagawa_loop_collector
    import kanagawa_loop_pkg::*;
#(
    parameter int unsigned TOTAL_WIDTH   = 128,
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned OFFSET        = 0,
    parameter int unsigned LAST_OFFSET   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   empty_in,
    input  logic [TOTAL_WIDTH-1:0] data_in,
    output logic                   rden_out,
    output logic [TOTAL_WIDTH-1:0] data_out,
    output logic                   empty_out,
    input  logic                   rden_in,
    output logic                   underflow_out,
    output logic                   seq_error_out
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1'b1);

    logic [COUNTER_WIDTH-1:0] id_s;
    logic [COUNTER_WIDTH-1:0] count_r;
    logic [COUNTER_WIDTH-1:0] expected_id_r;
    logic [TOTAL_WIDTH-1:0]   summary_s;
    logic                     last_s;
    logic                     pop_s;
    logic                     load_s;
    logic                     out_valid_s;
    logic                     seq_error_r;

    // Decode the head record and build the summary it would produce if last.
    always_comb begin
        id_s      = COUNTER_WIDTH'(field_extract(field_vec_t'(data_in), OFFSET, COUNTER_WIDTH));
        last_s    = is_last(field_vec_t'(data_in), LAST_OFFSET);
        summary_s = TOTAL_WIDTH'(field_insert(field_vec_t'(data_in), field_vec_t'(count_r),
                                              OFFSET, COUNTER_WIDTH));
    end

    // Non-last records always drain; only a last record waits for the holding register.
    assign pop_s    = rst & ~empty_in & (~last_s | ~out_valid_s | rden_in);
    assign load_s   = pop_s & last_s;
    assign rden_out = pop_s;

    // Per-loop record count and thread-ID continuity tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r       <= CNT_ZERO;
            expected_id_r <= CNT_ZERO;
            seq_error_r   <= 1'b0;
        end else if (pop_s) begin
            seq_error_r <= (id_s != expected_id_r);
            if (last_s) begin
                count_r       <= CNT_ZERO;
                expected_id_r <= CNT_ZERO;
            end else begin
                count_r       <= count_r + CNT_ONE;
                expected_id_r <= id_s + CNT_ONE;
            end
        end else begin
            seq_error_r <= 1'b0;
        end
    end

    kanagawa_loop_collector_out_reg #(
        .WIDTH (TOTAL_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (summary_s),
        .rden      (rden_in),
        .data      (data_out),
        .valid     (out_valid_s),
        .underflow (underflow_out)
    );

    assign empty_out     = ~out_valid_s;
    assign seq_error_out = seq_error_r;

endmodule
